// File: rtl/muldiv_issue_ctrl_if.sv
// Bundle of every non-clock signal of the MUL/DIV issue controller.
//   master : the controller itself (muldiv_issue_ctrl)
//   slave  : its environment (EXE request source, multiplier, divider, consumer)
// Groups: req_* (EXE request), mul_* (multiplier), div_* (divider),
//         resp_* (result), flush/unit_flush, opnd_a/b, busy/tmo_err, state_dbg.
interface muldiv_issue_ctrl_if #(
  parameter int XLEN  = 64,
  parameter int TAG_W = 5
);
  logic             req_valid;
  logic             req_ready;
  logic [3:0]       req_op;
  logic [XLEN-1:0]  req_src1;
  logic [XLEN-1:0]  req_src2;
  logic [TAG_W-1:0] req_tag;
  logic             flush;
  logic             mul_valid;
  logic             mul_ready;
  logic             mul_out_valid;
  logic [XLEN-1:0]  mul_hi;
  logic [XLEN-1:0]  mul_lo;
  logic             mul_w;
  logic [1:0]       mul_signed;
  logic             div_valid;
  logic             div_ready;
  logic             div_out_valid;
  logic [XLEN-1:0]  div_quo;
  logic [XLEN-1:0]  div_rem;
  logic             div_w;
  logic             div_signed;
  logic             unit_flush;
  logic [XLEN-1:0]  opnd_a;
  logic [XLEN-1:0]  opnd_b;
  logic             resp_valid;
  logic             resp_ready;
  logic [XLEN-1:0]  resp_data;
  logic [TAG_W-1:0] resp_tag;
  logic             busy;
  logic             tmo_err;
  logic [1:0]       state_dbg;

  modport master (
    input  req_valid, req_op, req_src1, req_src2, req_tag, flush,
           mul_ready, mul_out_valid, mul_hi, mul_lo,
           div_ready, div_out_valid, div_quo, div_rem, resp_ready,
    output req_ready, mul_valid, mul_w, mul_signed, div_valid, div_w, div_signed,
           unit_flush, opnd_a, opnd_b, resp_valid, resp_data, resp_tag,
           busy, tmo_err, state_dbg
  );

  modport slave (
    output req_valid, req_op, req_src1, req_src2, req_tag, flush,
           mul_ready, mul_out_valid, mul_hi, mul_lo,
           div_ready, div_out_valid, div_quo, div_rem, resp_ready,
    input  req_ready, mul_valid, mul_w, mul_signed, div_valid, div_w, div_signed,
           unit_flush, opnd_a, opnd_b, resp_valid, resp_data, resp_tag,
           busy, tmo_err, state_dbg
  );
endinterface

// File: rtl/muldiv_issue_ctrl.sv
// muldiv_issue_ctrl: sequences the shared shift-add multiplier and shift
// divider for the EXE stage. One request at a time: decode, one start pulse
// to the right unit, wait for its result, select/sign-extend, hold until
// consumed. Divide-by-zero is answered locally; flush and a watchdog abort.
// Ports: clock, reset (sync, active-high), bus (muldiv_issue_ctrl_if.master).
//
// Handshakes: a transfer happens on a rising edge where valid && ready.
// req: ready = (state==IDLE); a flush in the same cycle cancels acceptance.
// mul/div start: valid is raised only while the unit's ready is 1, so each
// raised cycle is exactly one accepted start. resp: valid held with stable
// data/tag until ready.
module muldiv_issue_ctrl #(
  parameter int XLEN    = 64,
  parameter int TAG_W   = 5,
  parameter int TMO_CYC = 127
) (
  input logic                clock,
  input logic                reset,
  muldiv_issue_ctrl_if.master bus
);
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_WAIT = 2'd2, S_DONE = 2'd3} state_t;

  state_t           state;
  logic [XLEN-1:0]  src1_q, src2_q, resp_q;
  logic [TAG_W-1:0] tag_q;
  logic             is_mul_q, word_q, alt_q;  // alt: mul -> hi half, div -> remainder
  logic             mul_w_q, div_w_q, div_signed_q;
  logic [1:0]       mul_signed_q;
  logic [7:0]       wd_cnt;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return {{(XLEN-32){v[31]}}, v};
  endfunction

  // request decode (IDLE only)
  logic            dec_mul, dec_div, dec_word, dec_alt, dec_zero;
  logic [1:0]      dec_msig;
  logic [XLEN-1:0] dz_data;

  always_comb begin
    dec_mul  = 1'b0;
    dec_msig = 2'b00;
    case (bus.req_op)
      4'b1001, 4'b0001, 4'b1000: begin dec_mul = 1'b1; dec_msig = 2'b11; end
      4'b0010:                   begin dec_mul = 1'b1; dec_msig = 2'b10; end
      4'b0011:                   begin dec_mul = 1'b1; dec_msig = 2'b00; end
      default:                   begin dec_mul = 1'b0; dec_msig = 2'b00; end
    endcase
    dec_div  = bus.req_op[2];
    dec_word = dec_mul ? (bus.req_op == 4'b1000) : bus.req_op[3];
    dec_alt  = dec_mul ? ~bus.req_op[3] : bus.req_op[1];
    dec_zero = bus.req_op[3] ? (bus.req_src2[31:0] == 32'd0) : (bus.req_src2 == '0);
    // x/0: quotient all ones, remainder the dividend
    if (bus.req_op[1])
      dz_data = bus.req_op[3] ? sext32(bus.req_src1[31:0]) : bus.req_src1;
    else
      dz_data = '1;
  end

  // unit handshake, result select and abort conditions
  logic            unit_out_valid, tmo_hit;
  logic [XLEN-1:0] res_raw, res_sel;

  always_comb begin
    unit_out_valid = is_mul_q ? bus.mul_out_valid : bus.div_out_valid;
    res_raw = is_mul_q ? (alt_q ? bus.mul_hi : bus.mul_lo)
                       : (alt_q ? bus.div_rem : bus.div_quo);
    res_sel = word_q ? sext32(res_raw[31:0]) : res_raw;
    // a result arriving on the timeout cycle wins over the abort
    tmo_hit = (state == S_WAIT) && (wd_cnt == 8'(TMO_CYC)) && !unit_out_valid && !bus.flush;
  end

  assign bus.req_ready  = (state == S_IDLE);
  assign bus.busy       = (state != S_IDLE);
  assign bus.state_dbg  = state;
  assign bus.mul_valid  = (state == S_ISSUE) && is_mul_q  && bus.mul_ready && !bus.flush;
  assign bus.div_valid  = (state == S_ISSUE) && !is_mul_q && bus.div_ready && !bus.flush;
  assign bus.unit_flush = (bus.flush && ((state == S_ISSUE) || (state == S_WAIT))) || tmo_hit;
  assign bus.tmo_err    = tmo_hit;
  assign bus.resp_valid = (state == S_DONE) && !bus.flush;
  assign bus.resp_data  = resp_q;
  assign bus.resp_tag   = tag_q;
  assign bus.opnd_a     = src1_q;
  assign bus.opnd_b     = src2_q;
  assign bus.mul_w      = mul_w_q;
  assign bus.mul_signed = mul_signed_q;
  assign bus.div_w      = div_w_q;
  assign bus.div_signed = div_signed_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= S_IDLE;
      src1_q       <= '0;
      src2_q       <= '0;
      resp_q       <= '0;
      tag_q        <= '0;
      is_mul_q     <= 1'b0;
      word_q       <= 1'b0;
      alt_q        <= 1'b0;
      mul_w_q      <= 1'b0;
      mul_signed_q <= 2'b00;
      div_w_q      <= 1'b0;
      div_signed_q <= 1'b0;
      wd_cnt       <= '0;
    end else if (bus.flush) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (bus.req_valid) begin
          src1_q       <= bus.req_src1;
          src2_q       <= bus.req_src2;
          tag_q        <= bus.req_tag;
          is_mul_q     <= dec_mul;
          word_q       <= dec_word;
          alt_q        <= dec_alt;
          mul_w_q      <= dec_mul && dec_word;
          mul_signed_q <= dec_mul ? dec_msig : 2'b00;
          div_w_q      <= dec_div && bus.req_op[3];
          div_signed_q <= dec_div && !bus.req_op[0];
          if (!dec_mul && !dec_div) begin
            resp_q <= '0;
            state  <= S_DONE;
          end else if (dec_div && dec_zero) begin
            resp_q <= dz_data;
            state  <= S_DONE;
          end else begin
            state <= S_ISSUE;
          end
        end
        S_ISSUE: if (bus.mul_valid || bus.div_valid) begin
          wd_cnt <= '0;
          state  <= S_WAIT;
        end
        S_WAIT: begin
          if (unit_out_valid) begin
            resp_q <= res_sel;
            state  <= S_DONE;
          end else if (tmo_hit) begin
            state <= S_IDLE;
          end else begin
            wd_cnt <= wd_cnt + 8'd1;
          end
        end
        S_DONE: if (bus.resp_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
